// File: rtl/leaf_pkg.sv
// Shared leaf-shell definitions: default payload width, debug counter width and
// the handshake helpers used by the inbound elastic buffers.
package leaf_pkg;

  localparam int PAYLOAD_BITS_DEF = 32;
  localparam int WORD_CNT_W       = 32;

  // Output-register steering for one cycle
  typedef enum logic [1:0] {
    OR_HOLD,
    OR_LOAD_IN,
    OR_LOAD_RAM,
    OR_DRAIN
  } or_op_e;

  function automatic logic xfer(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

endpackage

// File: rtl/leaf_sdp_ram.sv
// Simple dual-port RAM, one write and one registered read port. A read of the
// address being written in the same cycle returns the new word.
module leaf_sdp_ram #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 4,
  parameter int ENTRIES = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/leaf_user_in_fifo.sv
// Inbound elastic buffer between leaf_interface (vld/ack) and the user kernel
// (valid/ready): DEPTH-1 RAM entries plus a first-word-fall-through output register.
module leaf_user_in_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int DEPTH_BITS   = 4,
  parameter int AF_MARGIN    = 2
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] dout_user,
  output logic                    dout_user_vld,
  input  logic                    dout_user_rdy,
  output logic [DEPTH_BITS:0]     level,
  output logic                    almost_full,
  output logic [WORD_CNT_W-1:0]   word_cnt
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int RAM_N = DEPTH - 1;
  localparam logic [DEPTH_BITS:0]   LVL_FULL = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   LVL_AF   = (DEPTH_BITS + 1)'(DEPTH - AF_MARGIN);
  localparam logic [DEPTH_BITS:0]   LVL_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_LAST = DEPTH_BITS'(RAM_N - 1);

  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DEPTH_BITS:0]     level_nxt;
  logic [PAYLOAD_BITS-1:0] ram_rdata;
  logic                    push, pop, ram_empty, ram_we;
  or_op_e                  or_op;

  function automatic logic [DEPTH_BITS-1:0] ptr_inc(input logic [DEPTH_BITS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full-bypass is deliberately absent: acceptance depends on registered level only
  assign ack_user2interface = (level < LVL_FULL);
  assign push      = xfer(vld_interface2user, ack_user2interface);
  assign pop       = xfer(dout_user_vld, dout_user_rdy);
  assign ram_empty = (level <= LVL_ONE);

  always_comb begin
    or_op = OR_HOLD;
    if (!dout_user_vld) begin
      if (push) or_op = OR_LOAD_IN;
    end else if (pop) begin
      if (!ram_empty)  or_op = OR_LOAD_RAM;
      else if (push)   or_op = OR_LOAD_IN;
      else             or_op = OR_DRAIN;
    end
  end

  assign ram_we     = push && dout_user_vld && !(pop && ram_empty);
  assign wr_ptr_nxt = ram_we ? ptr_inc(wr_ptr) : wr_ptr;
  assign rd_ptr_nxt = (or_op == OR_LOAD_RAM) ? ptr_inc(rd_ptr) : rd_ptr;
  assign level_nxt  = level + {{DEPTH_BITS{1'b0}}, push} - {{DEPTH_BITS{1'b0}}, pop};

  // Read address runs one step ahead so ram_rdata always shows the next head word
  leaf_sdp_ram #(
    .WIDTH  (PAYLOAD_BITS),
    .ADDR_W (DEPTH_BITS),
    .ENTRIES(RAM_N)
  ) u_ram (
    .clk  (clk_user),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(dout_leaf_interface2user),
    .raddr(rd_ptr_nxt),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk_user) begin
    if (reset) begin
      level         <= '0;
      almost_full   <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      dout_user     <= '0;
      dout_user_vld <= 1'b0;
      word_cnt      <= '0;
    end else begin
      level       <= level_nxt;
      almost_full <= (level_nxt >= LVL_AF);
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      case (or_op)
        OR_LOAD_IN: begin
          dout_user     <= dout_leaf_interface2user;
          dout_user_vld <= 1'b1;
        end
        OR_LOAD_RAM: begin
          dout_user     <= ram_rdata;
          dout_user_vld <= 1'b1;
        end
        OR_DRAIN: dout_user_vld <= 1'b0;
        default: ;
      endcase
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Scoreboard bench for leaf_user_in_fifo: every accepted word is queued and
// compared in order when the kernel side pops it; flags are tracked per cycle.
module tb_leaf_user_in_fifo;

  localparam int DEPTH = 16;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        vld, rdy;
  logic        ack;
  logic [31:0] dout_user;
  logic        dout_user_vld;
  logic [4:0]  level;
  logic        almost_full;
  logic [31:0] word_cnt;

  leaf_user_in_fifo dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .dout_leaf_interface2user(din),
    .vld_interface2user      (vld),
    .ack_user2interface      (ack),
    .dout_user               (dout_user),
    .dout_user_vld           (dout_user_vld),
    .dout_user_rdy           (rdy),
    .level                   (level),
    .almost_full             (almost_full),
    .word_cnt                (word_cnt)
  );

  always #5 clk_user = ~clk_user;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_cnt = '0;
  int          max_lvl = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check state against the model, then account for the handshakes
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      output logic pushed, output logic popped);
    logic [31:0] head;
    @(negedge clk_user);
    vld = v; din = d; rdy = r;
    #1;
    chk("level", 64'(level), 64'(sb_q.size()));
    chk("ack", 64'(ack), 64'(sb_q.size() < DEPTH));
    chk("dout_vld", 64'(dout_user_vld), 64'(sb_q.size() != 0));
    chk("almost_full", 64'(almost_full), 64'(sb_q.size() >= DEPTH - 2));
    chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    if (int'(level) > max_lvl) max_lvl = int'(level);
    pushed = v && ack;
    popped = dout_user_vld && r;
    if (popped) begin
      if (sb_q.size() == 0) chk("pop_underflow", 64'(1), 64'(0));
      else begin
        head = sb_q.pop_front();
        chk("pop_data", 64'(dout_user), 64'(head));
        exp_cnt = exp_cnt + 1;
      end
    end
    if (pushed) sb_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk_user);
    reset = 1'b1; vld = 1'b0; rdy = 1'b0; din = '0;
    @(negedge clk_user);
    reset = 1'b0;
    sb_q.delete();
    exp_cnt = '0;
    #1;
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_dout_vld", 64'(dout_user_vld), 64'(0));
    chk("rst_dout", 64'(dout_user), 64'(0));
    chk("rst_ack", 64'(ack), 64'(1));
    chk("rst_af", 64'(almost_full), 64'(0));
    chk("rst_word_cnt", 64'(word_cnt), 64'(0));
  endtask

  initial begin
    logic        p, o;
    int          k, cyc, sent, recv;
    logic [31:0] d;

    reset = 1'b1; vld = 1'b0; rdy = 1'b0; din = '0;
    do_reset();

    // Single word, latency one, popped immediately
    step(1'b1, 32'hDEADBEEF, 1'b1, p, o);
    #0 chk("t1_pushed", 64'(p), 64'(1));
    step(1'b0, '0, 1'b1, p, o);
    chk("t1_popped", 64'(o), 64'(1));
    step(1'b0, '0, 1'b0, p, o);
    chk("t1_level", 64'(level), 64'(0));
    chk("t1_word_cnt", 64'(word_cnt), 64'(1));

    // Fill with kernel stalled
    k = 0;
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 32'(k), 1'b0, p, o);
      if (p) k++;
    end
    chk("t2_accepted", 64'(k), 64'(16));
    chk("t2_full_af", 64'(almost_full), 64'(1));

    // From full with both sides active: no bypass in the first full cycle
    step(1'b1, 32'(k), 1'b1, p, o);
    chk("t3_no_bypass", 64'(p), 64'(0));
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 32'(k), 1'b1, p, o);
      if (p) k++;
    end
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 64) begin
      step(1'b0, '0, 1'b1, p, o);
      cyc++;
    end
    chk("t3_drained", 64'(sb_q.size()), 64'(0));

    // Random traffic
    do_reset();
    sent = 0; recv = 0; cyc = 0; max_lvl = 0;
    while (recv < 10000 && cyc < 60000) begin
      d = $urandom;
      step((sent < 10000) && ($urandom_range(0, 1) == 1), d, $urandom_range(0, 1) == 1, p, o);
      if (p) sent++;
      if (o) recv++;
      cyc++;
    end
    chk("t4_recv", 64'(recv), 64'(10000));
    step(1'b0, '0, 1'b0, p, o);
    chk("t4_word_cnt", 64'(word_cnt), 64'(10000));
    chk("t4_max_level_ok", 64'(max_lvl <= DEPTH), 64'(1));

    // Reset mid-fill discards held words
    for (int c = 0; c < 9; c++) step(1'b1, 32'(1000 + c), 1'b0, p, o);
    step(1'b0, '0, 1'b0, p, o);
    chk("t5_level9", 64'(level), 64'(9));
    do_reset();
    step(1'b1, 32'hA5A5A5A5, 1'b0, p, o);
    step(1'b0, '0, 1'b1, p, o);
    chk("t5_first_out", 64'(dout_user), 64'(32'hA5A5A5A5));
    step(1'b0, '0, 1'b0, p, o);

    // word_cnt wrap
    step(1'b1, 32'h00001234, 1'b0, p, o);
    step(1'b0, '0, 1'b0, p, o);
    force dut.word_cnt = 32'hFFFFFFFF;
    #1 release dut.word_cnt;
    exp_cnt = 32'hFFFFFFFF;
    step(1'b0, '0, 1'b1, p, o);
    step(1'b0, '0, 1'b0, p, o);
    chk("t6_wrap", 64'(word_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
